pcr1_reagent_sequencer: RTL and testbench
=========================================

PCR1_REAGENT_SEQUENCER -- requirements
Module: pcr1_reagent_sequencer

Interface
REQ-001 SHALL have parameter NUM_INLETS, default 6: reagent inlets soln1..soln6, dosed in index order 0..5 (F prime, R prime, Evagreen, H2O, Taq, DNA).
REQ-002 SHALL have parameter DWELL_W, default 16: width of the dwell counter and dwell registers.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 64: post-dose mixer settle time.
REQ-004 SHALL have parameter FLUSH_CYCLES, default 256: output-serpentine flush time.
REQ-005 SHALL have parameter ACK_TIMEOUT, default 1023: maximum wait for a pump_ack edge.
REQ-006 SHALL use one clock; reset is asynchronous and active-high: clk  in  1  system clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 start  in  1  one-cycle request to run a full dosing sequence.
REQ-009 abort  in  1  stop the sequence immediately.
REQ-010 cfg_we  in  1  write strobe for a dwell register.
REQ-011 cfg_idx  in  3  index of the inlet dwell register being written.
REQ-012 cfg_val  in  DWELL_W  dwell value in cycles.
REQ-013 pump_req  out  1  request to open the valve and run the pump.
REQ-014 pump_ack  in  1  pump running (level); follows pump_req.
REQ-015 valve_sel  out  NUM_INLETS  one-hot open valve, or zero.
REQ-016 flush_en  out  1  flush the output serpentine.
REQ-017 stage  out  3  current inlet index.
REQ-018 busy  out  1  sequence active.
REQ-019 done  out  1  one-cycle completion pulse.
REQ-020 err  out  1  sticky error flag.

Function
REQ-021 FSM states SHALL be IDLE, OPEN, DOSE, CLOSE, SETTLE, FLUSH, DONE, ERROR.
REQ-022 IDLE->OPEN on start, with stage=first inlet whose dwell is nonzero; if all dwells are zero, IDLE->FLUSH.
REQ-023 OPEN: valve_sel=onehot(stage) and pump_req=1; on pump_ack=1 go to DOSE and load the counter with dwell[stage]-1.
REQ-024 DOSE: hold valve_sel and pump_req; decrement each cycle; at 0 go to CLOSE, so pump_ack dwell = dwell[stage] cycles.
REQ-025 CLOSE: pump_req=0, valve_sel stays; on pump_ack=0 go to SETTLE, valve_sel=0.
REQ-026 SETTLE: count SETTLE_CYCLES; then go to OPEN with the next inlet whose dwell is nonzero, else FLUSH.
REQ-027 FLUSH: flush_en=1, valve_sel=0 for FLUSH_CYCLES; then DONE.
REQ-028 DONE: done=1 for exactly one cycle; then IDLE.
REQ-029 If OPEN or CLOSE waits more than ACK_TIMEOUT cycles, go to ERROR.
REQ-030 abort in any non-IDLE state SHALL go to ERROR next cycle.
REQ-031 ERROR: pump_req=0, valve_sel=0, flush_en=0, err=1; stay until start, which clears err and starts a new run.
REQ-032 busy=1 in every state except IDLE and ERROR.
REQ-033 start SHALL be ignored while busy; abort has priority over start and over every counter expiry.
REQ-034 cfg_we SHALL write any time; a write to the current stage during DOSE takes effect on the next run; cfg_idx >= NUM_INLETS is ignored.
REQ-035 valve_sel SHALL never have more than one bit set, and SHALL be zero whenever flush_en=1.

Reset
REQ-036 On rst: state=IDLE; pump_req, valve_sel, flush_en, done, err, busy=0; stage=0; counter=0.
REQ-037 On rst: dwell registers=16 (decimal); rst mid-run SHALL close all valves immediately, asynchronously.

Structure
REQ-038 The state enum, NUM_INLETS, and the inlet index constants SHALL live in shared package pcr_ctrl_pkg.
REQ-039 Timers SHALL use one sub-module, seq_down_counter: load, enable, zero flag.

Verification
REQ-040 Dwells = {4,4,2,2,1,2}, zero-latency ack: start -> valve_sel walks 000001..100000, pump_ack high 4,4,2,2,1,2 cycles, SETTLE_CYCLES between each, then FLUSH_CYCLES flush_en, one done pulse.
REQ-041 Dwell[2]=0: inlet 2 skipped; valve_sel never 000100.
REQ-042 pump_ack held 0 in OPEN -> err=1 after ACK_TIMEOUT+1 cycles, valve_sel=0; a subsequent start clears err.
REQ-043 abort during DOSE of stage 3 -> next cycle pump_req=0, valve_sel=0, err=1, busy=0.
REQ-044 rst asserted mid-FLUSH -> outputs zero without a clock edge; dwell reads back 16.
REQ-045 start while busy and cfg_idx=7 writes -> no effect on the sequence or on stored dwells.

Source files
------------

// File: rtl/pcr_ctrl_pkg.sv
// Shared definitions for the PCR1 reagent dosing controller: inlet count, inlet
// order, sequencer states and a small constant helper.
package pcr_ctrl_pkg;

  localparam int NUM_INLETS  = 6;
  localparam int STAGE_W     = 3;
  localparam int DWELL_RESET = 16;

  typedef enum logic [2:0] {
    INLET_F_PRIME  = 3'd0,
    INLET_R_PRIME  = 3'd1,
    INLET_EVAGREEN = 3'd2,
    INLET_H2O      = 3'd3,
    INLET_TAQ      = 3'd4,
    INLET_DNA      = 3'd5
  } inlet_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OPEN   = 3'd1,
    DOSE   = 3'd2,
    CLOSE  = 3'd3,
    SETTLE = 3'd4,
    FLUSH  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter shared by every timed phase of the sequencer; it parks
// at zero and flags it.
module seq_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // load wins over enable; the count never wraps below zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pcr1_reagent_sequencer.sv
// Doses the PCR1 reagent inlets in order, lets the mixer settle after each dose,
// flushes the output serpentine and reports completion or a sticky error.
module pcr1_reagent_sequencer #(
  parameter int NUM_INLETS    = pcr_ctrl_pkg::NUM_INLETS,
  parameter int DWELL_W       = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int FLUSH_CYCLES  = 256,
  parameter int ACK_TIMEOUT   = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_idx,
  input  logic [DWELL_W-1:0]    cfg_val,
  output logic                  pump_req,
  input  logic                  pump_ack,
  output logic [NUM_INLETS-1:0] valve_sel,
  output logic                  flush_en,
  output logic [2:0]            stage,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  import pcr_ctrl_pkg::*;

  localparam int CNT_W = max_int(max_int(DWELL_W, $clog2(ACK_TIMEOUT + 1)),
                                 max_int($clog2(SETTLE_CYCLES + 1), $clog2(FLUSH_CYCLES + 1)));
  localparam logic [CNT_W-1:0] ACK_LOAD    = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES - 1);

  seq_state_e           state_r, state_s;
  logic [STAGE_W-1:0]   stage_r, stage_s;
  logic [DWELL_W-1:0]   dwell_r [NUM_INLETS];
  logic [DWELL_W-1:0]   dwell_cur_s;
  logic                 cnt_load_s, cnt_en_s, cnt_zero_s, cnt_last_s;
  logic [CNT_W-1:0]     cnt_val_s, cnt_q_s;
  logic                 first_ok_s, next_ok_s;
  logic [STAGE_W-1:0]   first_idx_s, next_idx_s;
  logic                 pump_req_s, flush_s, done_s, err_s, busy_s;
  logic [NUM_INLETS-1:0] valve_s;

  seq_down_counter #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .en       (cnt_en_s),
    .load_val (cnt_val_s),
    .count    (cnt_q_s),
    .zero     (cnt_zero_s)
  );

  assign dwell_cur_s = dwell_r[stage_r];
  // The OPEN cycle that sees the ack already counts as the first dose cycle.
  assign cnt_last_s  = (cnt_q_s <= CNT_W'(1));
  assign stage       = stage_r;

  // dwell register file; out-of-range indices are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_INLETS; i++) begin
        dwell_r[i] <= DWELL_W'(DWELL_RESET);
      end
    end else if (cfg_we && (int'(cfg_idx) < NUM_INLETS)) begin
      dwell_r[cfg_idx] <= cfg_val;
    end else begin
      dwell_r <= dwell_r;
    end
  end

  // first enabled inlet, and first enabled inlet after the current stage
  always_comb begin
    first_ok_s  = 1'b0;
    first_idx_s = '0;
    next_ok_s   = 1'b0;
    next_idx_s  = '0;
    for (int i = NUM_INLETS - 1; i >= 0; i--) begin
      if (dwell_r[i] != '0) begin
        first_ok_s  = 1'b1;
        first_idx_s = STAGE_W'(i);
        if (STAGE_W'(i) > stage_r) begin
          next_ok_s  = 1'b1;
          next_idx_s = STAGE_W'(i);
        end else begin
          next_ok_s = next_ok_s;
        end
      end else begin
        first_ok_s = first_ok_s;
      end
    end
  end

  // next-state and timer control; abort overrides everything outside IDLE
  always_comb begin
    state_s    = state_r;
    stage_s    = stage_r;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    cnt_val_s  = '0;
    case (state_r)
      IDLE, ERROR: begin
        if (start && first_ok_s) begin
          state_s    = OPEN;
          stage_s    = first_idx_s;
          cnt_load_s = 1'b1;
          cnt_val_s  = ACK_LOAD;
        end else if (start) begin
          state_s    = FLUSH;
          cnt_load_s = 1'b1;
          cnt_val_s  = FLUSH_LOAD;
        end else begin
          state_s = state_r;
        end
      end
      OPEN: begin
        if (pump_ack && (dwell_cur_s <= DWELL_W'(1))) begin
          state_s    = CLOSE;
          cnt_load_s = 1'b1;
          cnt_val_s  = ACK_LOAD;
        end else if (pump_ack) begin
          state_s    = DOSE;
          cnt_load_s = 1'b1;
          cnt_val_s  = CNT_W'(dwell_cur_s) - CNT_W'(1);
        end else if (cnt_zero_s) begin
          state_s = ERROR;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      DOSE: begin
        if (cnt_last_s) begin
          state_s    = CLOSE;
          cnt_load_s = 1'b1;
          cnt_val_s  = ACK_LOAD;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      CLOSE: begin
        if (!pump_ack) begin
          state_s    = SETTLE;
          cnt_load_s = 1'b1;
          cnt_val_s  = SETTLE_LOAD;
        end else if (cnt_zero_s) begin
          state_s = ERROR;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_zero_s && next_ok_s) begin
          state_s    = OPEN;
          stage_s    = next_idx_s;
          cnt_load_s = 1'b1;
          cnt_val_s  = ACK_LOAD;
        end else if (cnt_zero_s) begin
          state_s    = FLUSH;
          cnt_load_s = 1'b1;
          cnt_val_s  = FLUSH_LOAD;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_zero_s) begin
          state_s = DONE;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = ERROR;
    endcase
    if (abort && (state_r != IDLE)) begin
      state_s    = ERROR;
      cnt_load_s = 1'b0;
      cnt_en_s   = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // output decode from the upcoming state so every output is a flop
  always_comb begin
    pump_req_s = 1'b0;
    valve_s    = '0;
    flush_s    = 1'b0;
    done_s     = 1'b0;
    err_s      = 1'b0;
    busy_s     = 1'b1;
    case (state_s)
      IDLE:   busy_s = 1'b0;
      OPEN, DOSE: begin
        pump_req_s = 1'b1;
        valve_s    = {{(NUM_INLETS-1){1'b0}}, 1'b1} << stage_s;
      end
      CLOSE:  valve_s = {{(NUM_INLETS-1){1'b0}}, 1'b1} << stage_s;
      SETTLE: busy_s  = 1'b1;
      FLUSH:  flush_s = 1'b1;
      DONE:   done_s  = 1'b1;
      ERROR: begin
        err_s  = 1'b1;
        busy_s = 1'b0;
      end
      default: busy_s = 1'b0;
    endcase
  end

  // state and output registers; reset shuts every valve without a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      stage_r   <= INLET_F_PRIME;
      pump_req  <= 1'b0;
      valve_sel <= '0;
      flush_en  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      stage_r   <= stage_s;
      pump_req  <= pump_req_s;
      valve_sel <= valve_s;
      flush_en  <= flush_s;
      done      <= done_s;
      err       <= err_s;
      busy      <= busy_s;
    end
  end

endmodule

// File: tb/tb_pcr1_reagent_sequencer.sv
// Directed bench for pcr1_reagent_sequencer: a monitor turns pin activity into
// dose/settle/flush/done records which are scored against a dwell-table model.
module tb_pcr1_reagent_sequencer;
  localparam int NI = 6;
  localparam int DW = 16;
  localparam int SC = 64;
  localparam int FC = 256;
  localparam int AT = 1023;

  logic          clk = 1'b0;
  logic          rst, start, abort, cfg_we, ack_hold0;
  logic [2:0]    cfg_idx;
  logic [DW-1:0] cfg_val;
  logic          pump_req, pump_ack, flush_en, busy, done, err;
  logic [NI-1:0] valve_sel;
  logic [2:0]    stage;

  typedef struct {int kind; int a; int b;} rec_t;
  rec_t obs_q[$];
  rec_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int dw[NI];
  int m_valve, m_ack, m_set, m_fl;

  pcr1_reagent_sequencer #(
    .NUM_INLETS(NI), .DWELL_W(DW), .SETTLE_CYCLES(SC), .FLUSH_CYCLES(FC), .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_val(cfg_val), .pump_req(pump_req), .pump_ack(pump_ack), .valve_sel(valve_sel),
    .flush_en(flush_en), .stage(stage), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  assign pump_ack = pump_req & ~ack_hold0;

  function automatic rec_t mk(input int k, input int a, input int b);
    rec_t r;
    r.kind = k;
    r.a    = a;
    r.b    = b;
    return r;
  endfunction

  // kind 0 = dose {valve, ack cycles}, 1 = settle gap, 2 = flush length, 3 = done pulse
  always @(negedge clk) begin
    if (rst || !busy) begin
      m_valve = int'(valve_sel);
      m_ack   = 0;
      m_set   = 0;
      m_fl    = 0;
    end else begin
      if (int'(valve_sel) != m_valve) begin
        if (m_valve != 0) obs_q.push_back(mk(0, m_valve, m_ack));
        m_valve = int'(valve_sel);
        m_ack   = 0;
      end
      if (pump_ack) m_ack++;
      if (valve_sel == '0 && !flush_en && !done) m_set++;
      else if (m_set > 0) begin
        obs_q.push_back(mk(1, m_set, 0));
        m_set = 0;
      end
      if (flush_en) m_fl++;
      else if (m_fl > 0) begin
        obs_q.push_back(mk(2, m_fl, 0));
        m_fl = 0;
      end
      if (done) obs_q.push_back(mk(3, 1, 0));
    end
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < NI; i++) begin
      if (dw[i] != 0) begin
        exp_q.push_back(mk(0, 1 << i, dw[i]));
        exp_q.push_back(mk(1, SC, 0));
      end
    end
    exp_q.push_back(mk(2, FC, 0));
    exp_q.push_back(mk(3, 1, 0));
  endtask

  task automatic cmp_run(input string tag);
    rec_t e, o;
    check({tag, "_nrec"}, 96'(obs_q.size()), 96'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      else o = mk(-1, -1, -1);
      check({tag, "_rec"}, {o.kind, o.a, o.b}, {e.kind, e.a, e.b});
    end
  endtask

  task automatic cfg_write(input int idx, input int val);
    @(negedge clk);
    cfg_we  = 1'b1;
    cfg_idx = 3'(idx);
    cfg_val = DW'(val);
    @(negedge clk);
    cfg_we  = 1'b0;
    if (idx < NI) dw[idx] = val;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finish"}, 96'(busy), 96'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    cfg_idx = 3'd0; cfg_val = '0; ack_hold0 = 1'b0;
    for (int i = 0; i < NI; i++) dw[i] = 16;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", {pump_req, valve_sel, flush_en, busy, done, err}, 96'(0));
    check("rst_stage", 96'(stage), 96'(0));

    // nominal run with the reference dwell table
    cfg_write(0, 4); cfg_write(1, 4); cfg_write(2, 2);
    cfg_write(3, 2); cfg_write(4, 1); cfg_write(5, 2);
    build_exp(); obs_q.delete();
    pulse_start(); wait_idle("run1"); cmp_run("run1");

    // zero dwell skips inlet 2
    cfg_write(2, 0);
    build_exp(); obs_q.delete();
    pulse_start(); wait_idle("skip2"); cmp_run("skip2");

    // ack never arrives: timeout after ACK_TIMEOUT+1 cycles in OPEN
    cfg_write(3, 10);
    ack_hold0 = 1'b1;
    pulse_start();
    repeat (AT) @(negedge clk);
    check("tmo_err_early", {err, valve_sel}, {1'b0, 6'b000001});
    @(negedge clk);
    check("tmo_err", {err, busy, pump_req, valve_sel}, {1'b1, 1'b0, 1'b0, 6'b000000});

    // start from ERROR clears err and begins a run
    @(negedge clk);
    ack_hold0 = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_clear", {err, busy}, {1'b0, 1'b1});

    // abort during the dose of stage 3
    n = 0;
    while (!(stage == 3'd3 && pump_req) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach_stage3", {stage, pump_req}, {3'd3, 1'b1});
    @(negedge clk);
    check("in_dose3", {pump_req, valve_sel}, {1'b1, 6'b001000});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort", {pump_req, valve_sel, err, busy}, {1'b0, 6'b000000, 1'b1, 1'b0});

    // restart, then start while busy plus writes to illegal indices
    build_exp(); obs_q.delete();
    pulse_start();
    @(negedge clk);
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd7; cfg_val = '0;
    @(negedge clk);
    start = 1'b0; cfg_idx = 3'd6;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_idle("busy_start"); cmp_run("busy_start");

    // reset mid-flush closes everything without a clock edge
    pulse_start();
    n = 0;
    while (!flush_en && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach_flush", 96'(flush_en), 96'(1));
    #2 rst = 1'b1;
    #1 check("async_rst", {pump_req, valve_sel, flush_en, busy, done, err, stage}, 96'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) dw[i] = 16;
    build_exp(); obs_q.delete();
    pulse_start(); wait_idle("post_rst"); cmp_run("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
